// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: drives instruction-memory address, waits out the one-cycle
// registered read, captures the instruction and offers it over valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned INSTR_STRIDE = 3,
  parameter logic [2:0]  HALT_OPCODE  = 3'b111,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [2:0]            mem_opcode,
  input  logic [DATA_WIDTH-1:0] mem_data_A,
  input  logic [DATA_WIDTH-1:0] mem_data_B,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [2:0]            opcode,
  output logic [DATA_WIDTH-1:0] data_A,
  output logic [DATA_WIDTH-1:0] data_B,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_MEM, S_VALID, S_HALT} state_e;

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(INSTR_STRIDE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_MEM;
      S_MEM: begin
        opcode_d = mem_opcode;
        data_a_d = mem_data_A;
        data_b_d = mem_data_B;
        state_d  = S_VALID;
      end
      S_VALID: begin
        if (instr_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
          // halt keeps pc pointing at the halt instruction
          if (opcode_q == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            pc_d    = jump_en ? jump_addr : pc_q + STRIDE;
            state_d = S_ADDR;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      opcode_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign address     = pc_q;
  assign opcode      = opcode_q;
  assign data_A      = data_a_q;
  assign data_B      = data_b_q;
  assign instr_count = cnt_q;
  assign instr_valid = (state_q == S_VALID);
  assign busy        = (state_q == S_ADDR) || (state_q == S_MEM) || (state_q == S_VALID);
  assign halted      = (state_q == S_HALT);

endmodule
